// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and sizing helpers for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow-out cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first a - b over WIDTH cycles behind a start/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bi, r_borrow, w_d, w_bo, w_load, w_last;
  full_subtractor u_fs (.x(r_a[0]), .y(r_b[0]), .bi(r_bi), .d(w_d), .bo(w_bo));
  always_comb begin
    w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    w_load = start && (r_state != RUN);
    w_next = w_load ? RUN : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // diff/borrow only move on the final bit so they stay stable across later operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bi     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_bi  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_bi  <= w_bo;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= {w_d, r_res[WIDTH-1:1]};
        r_borrow <= w_bo;
      end
    end
  end
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with hand-computed differences, latency and handshake checks
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;
  int         n_chk = 0, n_fail = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 20) begin
      nb += int'(busy);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                    input logic eb, input string tag);
    int n, nb;
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy_cyc"}, nb, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    int n, nb, n2, seen;
    logic stable;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(8'd100, 8'd37, 8'd63, 1'b0, "sub_100_37");
    op(8'd5, 8'd9, 8'd252, 1'b1, "sub_5_9");
    op(8'd0, 8'd0, 8'd0, 1'b0, "sub_0_0");
    op(8'd255, 8'd255, 8'd0, 1'b0, "sub_255_255");
    op(8'd0, 8'd1, 8'd255, 1'b1, "sub_0_1");
    op(8'd255, 8'd0, 8'd255, 1'b0, "sub_255_0");

    // start pulsed mid-RUN must be ignored
    a = 8'd100; b = 8'd37; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'd0; b = 8'd0;
    wait_done(n, nb);
    chk("ign_lat", n + 3, 8);
    chk("ign_diff", diff, 63);
    chk("ign_borrow", borrow, 0);

    // back-to-back accept from DONE
    a = 8'd20; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'd200; b = 8'd201;
    chk("b2b_busy", busy, 1);
    stable = 1'b1;
    n2 = 1;
    while (!done && n2 < 20) begin
      if (diff !== 8'd63) stable = 1'b0;
      @(posedge clk); #1;
      n2++;
    end
    chk("b2b_hold_diff", stable, 1);
    chk("b2b_gap", n2, 9);
    chk("b2b_diff", diff, 17);
    chk("b2b_borrow", borrow, 0);
    @(posedge clk); #1;

    // async reset aborts mid-RUN
    a = 8'd100; b = 8'd37; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen += int'(done);
    end
    chk("abort_no_done", seen, 0);
    op(8'd20, 8'd3, 8'd17, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
